// File: rtl/nbit_countdown_timer.sv
// Loadable N-bit countdown timer; define NBIT_COUNTDOWN_AUTO_RELOAD_EN for periodic reload from the shadow value.
// count shows load_val one edge after start and done is a registered 1-cycle pulse; no backpressure, start ignored while busy.
`timescale 1ns/1ps
module nbit_countdown_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
  logic [N-1:0] shadow_q, shadow_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = load_val;
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
          shadow_d = load_val;
`endif
          // A zero load is a zero-length timer: pulse done without ever going busy.
          if (load_val != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (count_q == ONE) begin
          done_d = 1'b1;
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
          count_d = shadow_q;
`else
          count_d = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          count_d = count_q - ONE;
        end
      end

      PAUSED: begin
        // Leaving PAUSED costs one edge with no decrement.
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_nbit_countdown_timer.sv
// Bench for nbit_countdown_timer: directed scenarios plus random traffic against a rule-level model.
`timescale 1ns/1ps
module tb_nbit_countdown_timer;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] load_val;
  logic         start;
  logic         pause;
  logic         abort;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int errors;
  int checks;

  // Reference state: value shown, whether a count is active, whether we sit paused.
  int m_count;
  int m_busy;
  int m_paused;
  int m_done;
  int m_shadow;

  nbit_countdown_timer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_busy   = 0;
    m_paused = 0;
    m_done   = 0;
    m_shadow = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (m_busy == 0) begin
      if (start) begin
        m_count  = int'(load_val);
        m_shadow = int'(load_val);
        if (m_count == 0) begin
          m_done = 1;
        end else begin
          m_busy   = 1;
          m_paused = 0;
        end
      end
    end else if (abort) begin
      m_count = 0;
      m_busy  = 0;
    end else if (pause) begin
      m_paused = 1;
    end else if (m_paused != 0) begin
      m_paused = 0;
    end else if (m_count == 1) begin
      m_done = 1;
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
      m_count = m_shadow;
`else
      m_count = 0;
      m_busy  = 0;
`endif
    end else begin
      m_count = m_count - 1;
    end
  endtask

  // Called just after a falling edge: drive, clock, advance model, compare.
  task automatic tick(input logic s, input logic p, input logic a, input logic [N-1:0] lv);
    start    = s;
    pause    = p;
    abort    = a;
    load_val = lv;
    @(posedge clk);
    model_step();
    #1;
    chk("count", int'(count), m_count);
    chk("busy",  int'(busy),  m_busy);
    chk("done",  int'(done),  m_done);
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_count", int'(count), 0);
    chk("arst_busy",  int'(busy),  0);
    chk("arst_done",  int'(done),  0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    load_val = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_busy",  int'(busy),  0);
    chk("reset_done",  int'(done),  0);
    rst = 1'b1;

    // Async reset in the middle of a count of 9.
    tick(1'b1, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 20 && m_count != 6; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("pre_reset_count", int'(count), 6);
    mid_reset();
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("post_reset_count", int'(count), 0);

    // One-shot of 5.
    tick(1'b1, 1'b0, 1'b0, 4'd5);
    chk("oneshot_load", int'(count), 5);
    chk("oneshot_busy", int'(busy), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
      if (done) break;
    end
    chk("oneshot_len", n, 5);
    chk("oneshot_end_count", int'(count), 0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("oneshot_done_width", int'(done), 0);

    // Zero-length load.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("zero_done_clear", int'(done), 0);

    // Maximum load.
    tick(1'b1, 1'b0, 1'b0, 4'd15);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
      if (done) break;
    end
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
    chk("max_len", n, 15);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
`else
    chk("max_len", n, 15);
`endif

    // Pause of 4 cycles at count 3 during a load of 8.
    tick(1'b1, 1'b0, 1'b0, 4'd8);
    n = 0;
    for (int i = 0; i < 20 && m_count != 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'd0);
      n++;
      chk("pause_hold", int'(count), 3);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
      if (done) break;
    end
    chk("pause_total", n, 13);
`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
    tick(1'b0, 1'b0, 1'b1, 4'd0);
`endif

    // Start ignored while running, then abort.
    tick(1'b1, 1'b0, 1'b0, 4'd15);
    for (int i = 0; i < 20 && m_count != 7; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd2);
    chk("ignored_start", int'(count), 6);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("abort_count", int'(count), 0);
    chk("abort_busy",  int'(busy),  0);
    chk("abort_done",  int'(done),  0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 4'd0);

`ifdef NBIT_COUNTDOWN_AUTO_RELOAD_EN
    tick(1'b1, 1'b0, 1'b0, 4'd3);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("reload_count", int'(count), 3);
    chk("reload_done",  int'(done),  1);
    chk("reload_busy",  int'(busy),  1);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("reload_abort", int'(count), 0);
`endif

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      logic         s, p, a;
      logic [N-1:0] lv;
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 24) == 0);
      lv = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 15)) : N'($urandom_range(0, 3));
      tick(s, p, a, lv);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
